// File: rtl/otter_timer_pkg.sv
// Shared register offsets, CTRL bit positions and the CTRL register layout
// for the OTTER IOBUS down-counting timer.
package otter_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_COUNT  = 2'd1;
    localparam logic [1:0] TMR_RELOAD = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IE_BIT     = 2;
    localparam int CTRL_PRESC_LSB  = 8;
    localparam int PRESC_MAX_W     = 16;

    // presc is sized for the widest legal prescaler; narrower builds keep the upper bits at 0.
    typedef struct packed {
        logic [PRESC_MAX_W-1:0] presc;
        logic                   ie;
        logic                   auto;
        logic                   en;
    } timer_ctrl_t;

endpackage

// File: rtl/otter_iobus_timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (presc+1) enabled cycles.
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] r_pcnt;

    assign tick = en && (r_pcnt == presc);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_pcnt <= '0;
        end else if (clr || !en || tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/otter_iobus_timer.sv
// IOBUS responder timer: 16-byte register window, down-counter with prescaler,
// one-shot or auto-reload, sticky terminal-count flag and level interrupt.
module otter_iobus_timer
    import otter_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          PRESC_W   = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    // The bus has no handshake: reads are combinational and writes complete on
    // the strobe edge, so the responder never stalls the initiator.
    timer_ctrl_t r_ctrl;
    logic [31:0] r_count;
    logic [31:0] r_reload;
    logic        r_tc;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_count_wr;
    logic        w_reload_wr;
    logic        w_status_wr;
    logic        w_tick;
    timer_ctrl_t w_ctrl_nxt;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_sel       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign w_off       = IOBUS_ADDR[3:2];
    assign w_wr        = IOBUS_WR && w_sel;
    assign w_ctrl_wr   = w_wr && (w_off == TMR_CTRL);
    assign w_count_wr  = w_wr && (w_off == TMR_COUNT);
    assign w_reload_wr = w_wr && (w_off == TMR_RELOAD);
    assign w_status_wr = w_wr && (w_off == TMR_STATUS);

    assign w_unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT, r_ctrl};

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .en      (r_ctrl.en),
        .clr     (w_ctrl_wr),
        .presc   (r_ctrl.presc[PRESC_W-1:0]),
        .tick    (w_tick)
    );

    always_comb begin
        w_ctrl_nxt                    = '0;
        w_ctrl_nxt.en                 = IOBUS_OUT[CTRL_EN_BIT];
        w_ctrl_nxt.auto               = IOBUS_OUT[CTRL_AUTO_BIT];
        w_ctrl_nxt.ie                 = IOBUS_OUT[CTRL_IE_BIT];
        w_ctrl_nxt.presc[PRESC_W-1:0] = IOBUS_OUT[CTRL_PRESC_LSB +: PRESC_W];
    end

    // Later assignments win: a tick-set TC beats a W1C clear, and bus writes
    // to CTRL/COUNT beat the tick's EN clear, decrement or reload.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_ctrl   <= '0;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            if (w_status_wr && IOBUS_OUT[0]) begin
                r_tc <= 1'b0;
            end
            if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else begin
                    r_tc <= 1'b1;
                    if (r_ctrl.auto) begin
                        r_count <= r_reload;
                    end else begin
                        r_ctrl.en <= 1'b0;
                    end
                end
            end
            if (w_ctrl_wr) begin
                r_ctrl <= w_ctrl_nxt;
            end
            if (w_count_wr) begin
                r_count <= IOBUS_OUT;
            end
            if (w_reload_wr) begin
                r_reload <= IOBUS_OUT;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel) begin
            case (w_off)
                TMR_CTRL: begin
                    w_rdata[CTRL_EN_BIT]                   = r_ctrl.en;
                    w_rdata[CTRL_AUTO_BIT]                 = r_ctrl.auto;
                    w_rdata[CTRL_IE_BIT]                   = r_ctrl.ie;
                    w_rdata[CTRL_PRESC_LSB +: PRESC_W]     = r_ctrl.presc[PRESC_W-1:0];
                end
                TMR_COUNT:  w_rdata = r_count;
                TMR_RELOAD: w_rdata = r_reload;
                default:    w_rdata[0] = r_tc;
            endcase
        end
    end

    assign IOBUS_IN = w_rdata;
    assign INTR     = r_tc && r_ctrl.ie;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Randomised and directed bench for otter_iobus_timer; expected reads come from
// a closed-form tick-count model and are checked by a queue-driven monitor.
module tb_otter_iobus_timer;

    localparam logic [31:0] A_CTRL   = 32'h1100_0100;
    localparam logic [31:0] A_COUNT  = 32'h1100_0104;
    localparam logic [31:0] A_RELOAD = 32'h1100_0108;
    localparam logic [31:0] A_STATUS = 32'h1100_010C;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    logic [32:0] exp_q[$];
    logic [31:0] addr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    otter_iobus_timer #(
        .BASE_ADDR (32'h1100_0100),
        .PRESC_W   (8)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // monitor: read data is valid every cycle, checked mid-cycle
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [32:0] e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            n_checks++;
            if (IOBUS_IN !== e[31:0]) begin
                n_fail++;
                $display("FAIL rdata @%h: got %h expected %h (t=%0t)", a, IOBUS_IN, e[31:0], $time);
            end
            n_checks++;
            if (INTR !== e[32]) begin
                n_fail++;
                $display("FAIL intr @%h: got %b expected %b (t=%0t)", a, INTR, e[32], $time);
            end
        end
    end

    // driver: one bus cycle, optionally queueing the expected read for this cycle
    task automatic cyc(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                       input logic chk, input logic [31:0] exp_d, input logic exp_i);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = wr;
        if (chk) begin
            exp_q.push_back({exp_i, exp_d});
            addr_q.push_back(addr);
        end
        @(posedge CLK);
        #1;
        IOBUS_WR = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cyc(addr, 1'b1, data, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_i);
        cyc(addr, 1'b0, 32'h0, 1'b1, exp_d, exp_i);
    endtask

    task automatic quiesce();
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
    endtask

    // Reference: after n cycles from enable, k = n/(P+1) ticks have occurred.
    // Ticks 1..C count down; tick C+1 raises TC; auto mode then cycles R..0.
    task automatic run_scn(input int c, input int r, input int p, input int au,
                           input int ie, input int ncyc);
        logic [31:0] ctrl_w;
        quiesce();
        wr(A_RELOAD, 32'(r));
        wr(A_COUNT, 32'(c));
        ctrl_w = 32'((p << 8) | (ie << 2) | (au << 1) | 1);
        wr(A_CTRL, ctrl_w);
        for (int n = 0; n < ncyc; n++) begin
            int          k;
            int          off;
            logic        tc;
            logic        en;
            logic [31:0] cnt;
            logic [31:0] exp_d;
            k   = n / (p + 1);
            tc  = (k >= c + 1);
            en  = (au != 0) || (k < c + 1);
            if (k <= c)       cnt = 32'(c - k);
            else if (au != 0) cnt = 32'(r - ((k - c - 1) % (r + 1)));
            else              cnt = 32'h0;
            off = $urandom_range(0, 3);
            case (off)
                0:       exp_d = 32'((p << 8) | (ie << 2) | (au << 1)) | {31'h0, en};
                1:       exp_d = cnt;
                2:       exp_d = 32'(r);
                default: exp_d = {31'h0, tc};
            endcase
            rd(A_CTRL + 32'(off * 4) + 32'($urandom_range(0, 3)), exp_d, tc && (ie != 0));
        end
    endtask

    initial begin
        RESET_N    = 1'b0;
        IOBUS_ADDR = A_COUNT;
        IOBUS_OUT  = 32'd5;
        IOBUS_WR   = 1'b1;

        // reset wins over a concurrent COUNT write
        wr(A_COUNT, 32'd5);
        cyc(A_COUNT, 1'b1, 32'd5, 1'b1, 32'h0, 1'b0);
        RESET_N = 1'b1;
        rd(A_CTRL, 32'h0, 1'b0);
        rd(A_COUNT, 32'h0, 1'b0);
        rd(A_RELOAD, 32'h0, 1'b0);
        rd(A_STATUS, 32'h0, 1'b0);

        // one-shot, no prescale, IE on
        run_scn(3, 0, 0, 0, 1, 8);
        // auto-reload RELOAD=2, PRESC=3, IE off: 12-cycle period
        run_scn(2, 2, 3, 1, 0, 40);
        // enabling with COUNT=0 raises TC on the first tick
        run_scn(0, 1, 1, 0, 1, 6);

        // W1C clear racing a TC set: set wins, later clear takes effect
        quiesce();
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h5);
        rd(A_STATUS, 32'h0, 1'b0);
        rd(A_COUNT, 32'd1, 1'b0);
        cyc(A_STATUS, 1'b1, 32'h1, 1'b1, 32'h0, 1'b0);
        cyc(A_STATUS, 1'b1, 32'h1, 1'b1, 32'h1, 1'b1);
        rd(A_STATUS, 32'h0, 1'b0);
        rd(A_CTRL, 32'h4, 1'b0);

        // CTRL write beats the one-shot EN clear on the same edge
        quiesce();
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);
        cyc(A_CTRL, 1'b1, 32'h1, 1'b1, 32'h1, 1'b0);
        rd(A_CTRL, 32'h1, 1'b0);
        rd(A_CTRL, 32'h0, 1'b0);
        rd(A_STATUS, 32'h1, 1'b0);

        // decode: writes outside the window change nothing
        quiesce();
        wr(A_CTRL, 32'hFFFF_FF06);
        wr(A_COUNT, 32'h1234);
        wr(A_RELOAD, 32'hABCD);
        cyc(32'h1100_0110, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        cyc(32'h1100_00FC, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        rd(A_CTRL, 32'h0000_FF06, 1'b0);
        rd(A_COUNT, 32'h1234, 1'b0);
        rd(A_RELOAD, 32'hABCD, 1'b0);
        rd(A_STATUS, 32'h0, 1'b0);
        rd(32'h1100_0103, 32'h0000_FF06, 1'b0);

        // COUNT write beats the decrement on a tick edge
        quiesce();
        wr(A_COUNT, 32'h20);
        wr(A_CTRL, 32'h1);
        rd(A_COUNT, 32'h20, 1'b0);
        rd(A_COUNT, 32'h1F, 1'b0);
        cyc(A_COUNT, 1'b1, 32'h10, 1'b1, 32'h1E, 1'b0);
        rd(A_COUNT, 32'h10, 1'b0);
        rd(A_COUNT, 32'h0F, 1'b0);

        // randomised scenarios against the closed-form model
        for (int s = 0; s < 10; s++) begin
            run_scn($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 1), 30 + $urandom_range(0, 20));
        end

        // mid-count reset abandons the count without TC
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h5);
        RESET_N = 1'b0;
        wr(A_CTRL, 32'h0);
        RESET_N = 1'b1;
        rd(A_STATUS, 32'h0, 1'b0);
        rd(A_COUNT, 32'h0, 1'b0);

        repeat (3) @(posedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_iobus_timer.md
Name: otter_iobus_timer

Overview:
Memory-mapped down-counting timer that sits on the OTTER MCU IOBUS as a responder. The MCU is the initiator, driving IOBUS_ADDR, IOBUS_OUT and IOBUS_WR. This block decodes its 16-byte window, returns read data on IOBUS_IN, and raises the MCU INTR line on terminal count. It is instantiated inside OTTER_Wrapper beside the LED, switch and seven-segment peripherals, and its read data is OR-ed into the shared IOBUS_IN mux.

Parameters:
BASE_ADDR, 32'h1100_0100, window base; must be 16-byte aligned
PRESC_W, 8, prescaler width in bits (1..16)

Ports:
CLK  in  1  system clock, all logic rising-edge
RESET_N  in  1  synchronous, active-low reset
IOBUS_ADDR  in  32  byte address from MCU
IOBUS_OUT  in  32  write data from MCU
IOBUS_WR  in  1  single-cycle write strobe
IOBUS_IN  out  32  read data; 0 when the address is outside the window
INTR  out  1  level interrupt to MCU

Behaviour:
- Select: sel = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]). Register offset = IOBUS_ADDR[3:2]. IOBUS_ADDR[1:0] is ignored.
- Register map:
  - 0x0 CTRL: [0] EN, [1] AUTO (auto-reload), [2] IE, [8+:PRESC_W] PRESC. All other bits read 0.
  - 0x4 COUNT: 32-bit.
  - 0x8 RELOAD: 32-bit.
  - 0xC STATUS: [0] TC, write-1-to-clear; other bits read 0.
- Reads: combinational, zero latency. IOBUS_IN = selected register when sel, else 32'h0.
- Writes: take effect on the CLK edge where IOBUS_WR=1 and sel=1. Writes with sel=0 are ignored.
- Reset (RESET_N=0 at the edge): CTRL, COUNT, RELOAD, TC and the prescaler all go to 0, so IOBUS_IN=0 and INTR=0 on the next cycle. Reset mid-count abandons the count with no TC.
- Prescaler:
  - Internal pcnt[PRESC_W-1:0] runs while EN=1.
  - tick = EN && (pcnt == PRESC). On tick, pcnt wraps to 0; otherwise it increments.
  - PRESC=0 gives a tick every cycle.
  - pcnt is held at 0 while EN=0, and is cleared on any CTRL write.
- Count, on tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: TC <= 1. If AUTO, COUNT <= RELOAD; otherwise EN <= 0 (one-shot stop) and COUNT stays 0.
  - Period is (RELOAD+1)*(PRESC+1) cycles.
- Priority and simultaneous events:
  - A COUNT write overrides a tick decrement or reload in the same cycle.
  - A CTRL write overrides the one-shot EN clear in the same cycle.
  - A STATUS write of bit0=1 clears TC, but a TC set in the same cycle wins (TC stays 1).
- Wrap-around: enabling with COUNT=0 sets TC on the first tick. Arithmetic is unsigned 32-bit and never decrements below 0.
- INTR = TC & IE, registered-source level with no pulse stretching. Clearing IE masks INTR without losing TC.
- Free-running with no MCU activity requires no handshake. The block never stalls the bus.

Decomposition:
- Package otter_timer_pkg holds: the offset localparams (TMR_CTRL=2'd0, TMR_COUNT=2'd1, TMR_RELOAD=2'd2, TMR_STATUS=2'd3), the CTRL bit-index constants, and a packed struct timer_ctrl_t {presc, ie, auto, en}.
- Single sub-module timer_prescaler (CLK, RESET_N, en, clr, presc, tick) isolates the prescale counter. Everything else lives in otter_iobus_timer.

Test Plan:
1. Reset: hold RESET_N=0 for 2 cycles with IOBUS_WR=1 to 0x1100_0104, data 5 -> COUNT reads 0, INTR=0, IOBUS_IN=0 for all four offsets.
2. One-shot: write COUNT=3, then CTRL=0x5 (EN, IE, PRESC=0) -> COUNT reads 2,1,0 on consecutive cycles; TC=1 and INTR=1 on the 4th tick; EN reads 0; COUNT holds 0.
3. Auto-reload with prescale:
   - Stimulus: write RELOAD=2, COUNT=2, then CTRL=0x303 (EN, AUTO, PRESC=3).
   - Response: TC set every 12 cycles; COUNT sequence 2,1,0,2 changes every 4 cycles; INTR stays 0 (IE=0).
4. Clear race: write STATUS=1 on the same edge TC would set -> TC reads 1. A STATUS=1 write one cycle later -> TC reads 0 and INTR drops.
5. Decode:
   - Write 0xFFFF_FFFF to 0x1100_0110 (outside window) -> no register changes; IOBUS_IN=0 at that address.
   - Read 0x1100_0103 -> returns CTRL with unused bits 0.
6. COUNT write priority: with PRESC=0 and EN=1, write COUNT=0x10 on a tick edge -> COUNT reads 0x10 (not 0x0F); the next cycle reads 0x0F.
